// File: rtl/pressure_com_pkg.sv
// Shared types and width helpers for the pressure centre-of-mass block.
package pressure_com_pkg;

  localparam int QW = 11;

  typedef enum logic [2:0] {ACCUM, CHECK, DIV_X, DIV_Y, DONE} state_e;

  function automatic int total_w(input int dw, input int cells);
    return dw + $clog2(cells);
  endfunction

  function automatic int idx_acc_w(input int tot_w, input int wires);
    return tot_w + $clog2(wires);
  endfunction

endpackage

// File: rtl/pressure_com_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses exactly QW cycles after start.
// The final bit is resolved combinationally in the done cycle, so quot is only meaningful while done=1.
module com_divider #(
  parameter int NUM_W = 26,
  parameter int DEN_W = 16,
  parameter int QW    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [QW-1:0]    quot
);
  localparam int CW    = NUM_W + DEN_W + QW;
  localparam int CNT_W = $clog2(QW + 1);

  logic [CW-1:0]    rem_q, rem_d, dsh_q, dsh_d;
  logic [QW-1:0]    q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d, busy_q, busy_d;
  logic             ge, last;

  assign ge   = (rem_q >= dsh_q);
  assign last = busy_q && (cnt_q == CNT_W'(QW - 1));

  always_comb begin
    rem_d  = rem_q;
    dsh_d  = dsh_q;
    q_d    = q_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    busy_d = busy_q;
    if (start) begin
      rem_d  = CW'(num);
      dsh_d  = CW'(den) << (QW - 1);
      // A quotient that would not fit in QW bits (or den=0) saturates.
      ovf_d  = (CW'(num) >= (CW'(den) << QW));
      q_d    = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (ge) rem_d = rem_q - dsh_q;
      dsh_d = dsh_q >> 1;
      q_d   = {q_q[QW-2:0], ge};
      cnt_d = cnt_q + CNT_W'(1);
      if (last) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      dsh_q  <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dsh_q  <= dsh_d;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = last;
  assign quot = ovf_q ? {QW{1'b1}} : {q_q[QW-2:0], ge};

endmodule

// File: rtl/pressure_com.sv
// Accumulates one tactile frame of weighted samples and divides out the pressure centre in pixels.
// Touch frames report 25 cycles after the last sample, light frames after 2; input stalls meanwhile.
module pressure_com
  import pressure_com_pkg::*;
#(
  parameter int SW_WIRE_CNT = 16,
  parameter int RD_WIRE_CNT = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int NOISE_FLOOR = 8,
  parameter int MIN_TOTAL   = 64,
  parameter int CELL_PX     = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_valid,
  output logic                           sample_ready,
  input  logic [DATA_WIDTH-1:0]          sample_data,
  input  logic [$clog2(SW_WIRE_CNT)-1:0] sample_sw,
  input  logic [$clog2(RD_WIRE_CNT)-1:0] sample_rd,
  input  logic                           sample_last,
  output logic [10:0]                    x_com,
  output logic [9:0]                     y_com,
  output logic                           touch,
  output logic                           frame_done
);
  localparam int TOT_W   = total_w(DATA_WIDTH, SW_WIRE_CNT * RD_WIRE_CNT);
  localparam int SX_W    = idx_acc_w(TOT_W, SW_WIRE_CNT);
  localparam int SY_W    = idx_acc_w(TOT_W, RD_WIRE_CNT);
  localparam int CP_LOG2 = $clog2(CELL_PX);
  localparam int NUM_W   = ((SX_W > SY_W) ? SX_W : SY_W) + 1 + CP_LOG2;

  state_e              state_q, state_d;
  logic [TOT_W-1:0]    tot_q, tot_d;
  logic [SX_W-1:0]     sx_q, sx_d;
  logic [SY_W-1:0]     sy_q, sy_d;
  logic [QW-1:0]       xres_q, xres_d;
  logic [10:0]         x_com_q, x_com_d;
  logic [9:0]          y_com_q, y_com_d;
  logic                touch_q, touch_d, ystart_q, ystart_d;
  logic [DATA_WIDTH-1:0] w;
  logic                in_range, xfer, start_x;
  logic [NUM_W-1:0]    num_x, num_y, div_num;
  logic                div_busy, div_done;
  logic [QW-1:0]       div_quot;

  assign in_range = (int'(sample_sw) < SW_WIRE_CNT) && (int'(sample_rd) < RD_WIRE_CNT);
  assign w = (in_range && (sample_data > DATA_WIDTH'(NOISE_FLOOR)))
             ? sample_data - DATA_WIDTH'(NOISE_FLOOR) : '0;

  assign sample_ready = (state_q == ACCUM) && !div_busy;
  assign xfer         = sample_valid && sample_ready;

  // Adding total/2 before the divide lands the result on the centre of the weighted cell.
  assign num_x   = (NUM_W'(sx_q) + NUM_W'(tot_q >> 1)) << CP_LOG2;
  assign num_y   = (NUM_W'(sy_q) + NUM_W'(tot_q >> 1)) << CP_LOG2;
  assign div_num = ystart_q ? num_y : num_x;

  always_comb begin
    state_d  = state_q;
    tot_d    = tot_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    xres_d   = xres_q;
    x_com_d  = x_com_q;
    y_com_d  = y_com_q;
    touch_d  = touch_q;
    ystart_d = 1'b0;
    start_x  = 1'b0;
    unique case (state_q)
      ACCUM: if (xfer) begin
        tot_d = tot_q + TOT_W'(w);
        sx_d  = sx_q + (SX_W'(w) * SX_W'(sample_sw));
        sy_d  = sy_q + (SY_W'(w) * SY_W'(sample_rd));
        if (sample_last) state_d = CHECK;
      end
      CHECK: if (tot_q < TOT_W'(MIN_TOTAL)) begin
        touch_d = 1'b0;
        state_d = DONE;
      end else begin
        start_x = 1'b1;
        state_d = DIV_X;
      end
      DIV_X: if (div_done) begin
        xres_d   = div_quot;
        ystart_d = 1'b1;
        state_d  = DIV_Y;
      end
      // Outputs load on entry to DONE so they are visible alongside frame_done.
      DIV_Y: if (div_done) begin
        x_com_d = xres_q;
        y_com_d = div_quot[9:0];
        touch_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        tot_d   = '0;
        sx_d    = '0;
        sy_d    = '0;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ACCUM;
      tot_q    <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      xres_q   <= '0;
      x_com_q  <= '0;
      y_com_q  <= '0;
      touch_q  <= 1'b0;
      ystart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tot_q    <= tot_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      xres_q   <= xres_d;
      x_com_q  <= x_com_d;
      y_com_q  <= y_com_d;
      touch_q  <= touch_d;
      ystart_q <= ystart_d;
    end
  end

  com_divider #(.NUM_W(NUM_W), .DEN_W(TOT_W), .QW(QW)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (start_x || ystart_q),
    .num   (div_num),
    .den   (tot_q),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot)
  );

  assign x_com      = x_com_q;
  assign y_com      = y_com_q;
  assign touch      = touch_q;
  assign frame_done = (state_q == DONE);

endmodule
